rtsnoc_axi4lite_master: RTL and testbench

RTSNOC_AXI4LITE_MASTER -- requirements
Module: rtsnoc_axi4lite_master

---
 rtl/rtsnoc_pkg.sv | 29 ++
 rtl/rtsnoc_axi4lite_master.sv | 212 +++++++++++++++++++++
 tb/tb_rtsnoc_axi4lite_master.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtsnoc_pkg.sv
// Flit field layout, opcode bit and AXI response codes shared by the RTSNoC
// AXI4-Lite master bridge and the slave-side proxy.
package rtsnoc_pkg;

  // Request/response payload fields (bit offsets inside the payload)
  localparam int PL_WRITE_BIT = 55;
  localparam int PL_WSTRB_LO  = 51;
  localparam int PL_WSTRB_W   = 4;
  localparam int PL_RESP_LO   = 53;
  localparam int PL_RESP_W    = 2;
  localparam int PL_WA_LO     = 32;
  localparam int PL_WA_W      = 19;
  localparam int PL_DATA_W    = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Width of one node address {x, y, local}; a flit header carries two of them.
  function automatic int noc_node_width(input int size_x, input int size_y);
    return size_x + size_y + 3;
  endfunction

  function automatic int noc_header_width(input int size_x, input int size_y);
    return 2 * noc_node_width(size_x, size_y);
  endfunction

endpackage

// File: rtl/rtsnoc_axi4lite_master.sv
// NoC-to-AXI4-Lite master bridge: executes one request flit at a time on AXI
// and returns a response flit to the requesting node.
module rtsnoc_axi4lite_master
  import rtsnoc_pkg::*;
#(
  parameter int          NOC_X          = 0,
  parameter int          NOC_Y          = 0,
  parameter int          NOC_LOCAL_ADR  = 0,
  parameter int          SOC_SIZE_X     = 1,
  parameter int          SOC_SIZE_Y     = 1,
  parameter int          NOC_DATA_WIDTH = 56,
  parameter logic [31:0] AXI_BASE_ADDR  = 32'h0,
  localparam int         NOC_BUS_SIZE   = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NOC_BUS_SIZE-1:0] noc_dout_i,
  input  logic                    noc_nd_i,
  output logic                    noc_rd_o,
  output logic [NOC_BUS_SIZE-1:0] noc_din_o,
  output logic                    noc_wr_o,
  input  logic                    noc_wait_i,
  output logic [31:0]             axi_awaddr_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [31:0]             axi_wdata_o,
  output logic [3:0]              axi_wstrb_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o,
  output logic [31:0]             axi_araddr_o,
  output logic                    axi_arvalid_o,
  input  logic                    axi_arready_i,
  input  logic [31:0]             axi_rdata_i,
  input  logic [1:0]              axi_rresp_i,
  input  logic                    axi_rvalid_i,
  output logic                    axi_rready_o
);

  localparam int NODE_W = noc_node_width(SOC_SIZE_X, SOC_SIZE_Y);
  localparam logic [NODE_W-1:0] OWN_ADDR =
    {NOC_X[SOC_SIZE_X-1:0], NOC_Y[SOC_SIZE_Y-1:0], NOC_LOCAL_ADR[2:0]};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WR_ADDR_DATA,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_SEND
  } state_t;

  state_t                  state_reg;
  logic                    noc_rd_reg;
  logic                    noc_wr_reg;
  logic [NOC_BUS_SIZE-1:0] noc_din_reg;
  logic [31:0]             awaddr_reg;
  logic                    awvalid_reg;
  logic [31:0]             wdata_reg;
  logic [3:0]              wstrb_reg;
  logic                    wvalid_reg;
  logic                    bready_reg;
  logic [31:0]             araddr_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;
  logic [NODE_W-1:0]       req_src_reg;
  logic                    req_write_reg;
  logic [PL_WA_W-1:0]      req_wa_reg;

  // Incoming flit decode, valid while FETCH presents the flit
  logic [NODE_W-1:0]  in_dst;
  logic [NODE_W-1:0]  in_src;
  logic               in_write;
  logic [PL_WA_W-1:0] in_wa;
  logic [31:0]        in_addr;
  logic               in_match;

  assign in_dst   = noc_dout_i[NOC_DATA_WIDTH +: NODE_W];
  assign in_src   = noc_dout_i[NOC_DATA_WIDTH + NODE_W +: NODE_W];
  assign in_write = noc_dout_i[PL_WRITE_BIT];
  assign in_wa    = noc_dout_i[PL_WA_LO +: PL_WA_W];
  assign in_addr  = AXI_BASE_ADDR + {{(32-PL_WA_W-2){1'b0}}, in_wa, 2'b00};
  assign in_match = (in_dst == OWN_ADDR);

  // Response flit built from whichever AXI response channel completes the request
  logic [PL_RESP_W-1:0]      resp_sel;
  logic [PL_DATA_W-1:0]      data_sel;
  logic [NOC_DATA_WIDTH-1:0] resp_payload;
  logic [NOC_BUS_SIZE-1:0]   resp_flit;

  always_comb begin
    resp_sel = axi_bresp_i;
    data_sel = '0;
    if (!req_write_reg) begin
      resp_sel = axi_rresp_i;
      data_sel = axi_rdata_i;
    end
    resp_payload                           = '0;
    resp_payload[PL_WRITE_BIT]             = req_write_reg;
    resp_payload[PL_RESP_LO +: PL_RESP_W]  = resp_sel;
    resp_payload[PL_WA_LO +: PL_WA_W]      = req_wa_reg;
    resp_payload[0 +: PL_DATA_W]           = data_sel;
  end

  assign resp_flit = {OWN_ADDR, req_src_reg, resp_payload};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      noc_rd_reg    <= 1'b0;
      noc_wr_reg    <= 1'b0;
      noc_din_reg   <= '0;
      awaddr_reg    <= '0;
      awvalid_reg   <= 1'b0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      araddr_reg    <= '0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      req_src_reg   <= '0;
      req_write_reg <= 1'b0;
      req_wa_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (noc_nd_i) begin
            noc_rd_reg <= 1'b1;
            state_reg  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          noc_rd_reg    <= 1'b0;
          req_src_reg   <= in_src;
          req_write_reg <= in_write;
          req_wa_reg    <= in_wa;
          if (!in_match) begin
            state_reg <= ST_IDLE;
          end else if (in_write) begin
            awaddr_reg  <= in_addr;
            wdata_reg   <= noc_dout_i[0 +: PL_DATA_W];
            wstrb_reg   <= noc_dout_i[PL_WSTRB_LO +: PL_WSTRB_W];
            awvalid_reg <= 1'b1;
            wvalid_reg  <= 1'b1;
            state_reg   <= ST_WR_ADDR_DATA;
          end else begin
            araddr_reg  <= in_addr;
            arvalid_reg <= 1'b1;
            state_reg   <= ST_RD_ADDR;
          end
        end
        ST_WR_ADDR_DATA: begin
          // A deasserted valid here means that channel has already handshaken
          if (axi_awready_i) awvalid_reg <= 1'b0;
          if (axi_wready_i)  wvalid_reg  <= 1'b0;
          if ((!awvalid_reg || axi_awready_i) && (!wvalid_reg || axi_wready_i)) begin
            bready_reg <= 1'b1;
            state_reg  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (axi_bvalid_i) begin
            bready_reg  <= 1'b0;
            noc_din_reg <= resp_flit;
            noc_wr_reg  <= 1'b1;
            state_reg   <= ST_SEND;
          end
        end
        ST_RD_ADDR: begin
          if (axi_arready_i) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (axi_rvalid_i) begin
            rready_reg  <= 1'b0;
            noc_din_reg <= resp_flit;
            noc_wr_reg  <= 1'b1;
            state_reg   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!noc_wait_i) begin
            noc_wr_reg <= 1'b0;
            state_reg  <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign noc_rd_o      = noc_rd_reg;
  assign noc_wr_o      = noc_wr_reg;
  assign noc_din_o     = noc_din_reg;
  assign axi_awaddr_o  = awaddr_reg;
  assign axi_awvalid_o = awvalid_reg;
  assign axi_wdata_o   = wdata_reg;
  assign axi_wstrb_o   = wstrb_reg;
  assign axi_wvalid_o  = wvalid_reg;
  assign axi_bready_o  = bready_reg;
  assign axi_araddr_o  = araddr_reg;
  assign axi_arvalid_o = arvalid_reg;
  assign axi_rready_o  = rready_reg;

endmodule

// File: tb/tb_rtsnoc_axi4lite_master.sv
// Directed bench for the RTSNoC AXI4-Lite master bridge: a vector table of
// request flits against a small AXI slave model, plus reset corner cases.
module tb_rtsnoc_axi4lite_master;

  localparam int BUS_W = 66;

  logic             clk = 1'b0;
  logic             rst_n_i;
  logic [BUS_W-1:0] noc_dout_i;
  logic             noc_nd_i;
  logic             noc_rd_o;
  logic [BUS_W-1:0] noc_din_o;
  logic             noc_wr_o;
  logic             noc_wait_i;
  logic [31:0]      axi_awaddr_o;
  logic             axi_awvalid_o;
  logic             axi_awready_i;
  logic [31:0]      axi_wdata_o;
  logic [3:0]       axi_wstrb_o;
  logic             axi_wvalid_o;
  logic             axi_wready_i;
  logic [1:0]       axi_bresp_i;
  logic             axi_bvalid_i;
  logic             axi_bready_o;
  logic [31:0]      axi_araddr_o;
  logic             axi_arvalid_o;
  logic             axi_arready_i;
  logic [31:0]      axi_rdata_i;
  logic [1:0]       axi_rresp_i;
  logic             axi_rvalid_i;
  logic             axi_rready_o;

  always #5 clk = ~clk;

  rtsnoc_axi4lite_master #(
    .NOC_X(1), .NOC_Y(0), .NOC_LOCAL_ADR(2),
    .SOC_SIZE_X(1), .SOC_SIZE_Y(1),
    .NOC_DATA_WIDTH(56), .AXI_BASE_ADDR(32'h4000_0000)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .noc_dout_i(noc_dout_i), .noc_nd_i(noc_nd_i), .noc_rd_o(noc_rd_o),
    .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o), .noc_wait_i(noc_wait_i),
    .axi_awaddr_o(axi_awaddr_o), .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wvalid_o(axi_wvalid_o),
    .axi_wready_i(axi_wready_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i),
    .axi_bready_o(axi_bready_o), .axi_araddr_o(axi_araddr_o), .axi_arvalid_o(axi_arvalid_o),
    .axi_arready_i(axi_arready_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
    .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o)
  );

  logic any_out;
  assign any_out = |{noc_rd_o, noc_din_o, noc_wr_o, axi_awaddr_o, axi_awvalid_o,
                     axi_wdata_o, axi_wstrb_o, axi_wvalid_o, axi_bready_o,
                     axi_araddr_o, axi_arvalid_o, axi_rready_o};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave configuration and observation counters
  int          aw_dly, w_dly, ar_dly;
  logic [1:0]  slv_resp;
  logic [31:0] slv_rdata;
  bit          b_hold;
  int          rd_pulses, aw_cycles, w_cycles, ar_cycles, b_hs, r_hs;
  int          wr_cycles, flit_cnt, stab_err;
  logic [BUS_W-1:0] cap_flit;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  task automatic clear_mon();
    rd_pulses = 0; aw_cycles = 0; w_cycles = 0; ar_cycles = 0; b_hs = 0; r_hs = 0;
    wr_cycles = 0; flit_cnt = 0; stab_err = 0;
    cap_flit = '0; cap_addr = '0; cap_wdata = '0; cap_wstrb = '0;
  endtask

  // Monitor on the falling edge, slave responses just after the rising edge
  bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
  bit p_aw, p_w, p_ar, p_wr, aw_flag, w_flag;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  logic [3:0]  p_wstrb;
  logic [BUS_W-1:0] p_din;
  int aw_cnt, w_cnt, ar_cnt;

  initial begin
    axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0; axi_bresp_i = 0;
    axi_arready_i = 0; axi_rvalid_i = 0; axi_rdata_i = 0; axi_rresp_i = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_flag = 0; w_flag = 0;
    p_aw = 0; p_w = 0; p_ar = 0; p_wr = 0;
    forever begin
      @(negedge clk);
      hs_aw = axi_awvalid_o && axi_awready_i;
      hs_w  = axi_wvalid_o && axi_wready_i;
      hs_b  = axi_bvalid_i && axi_bready_o;
      hs_ar = axi_arvalid_o && axi_arready_i;
      hs_r  = axi_rvalid_i && axi_rready_o;
      if (noc_rd_o) rd_pulses++;
      if (axi_awvalid_o) aw_cycles++;
      if (axi_wvalid_o) w_cycles++;
      if (axi_arvalid_o) ar_cycles++;
      if (hs_aw) cap_addr = axi_awaddr_o;
      if (hs_ar) cap_addr = axi_araddr_o;
      if (hs_w) begin cap_wdata = axi_wdata_o; cap_wstrb = axi_wstrb_o; end
      if (hs_b) b_hs++;
      if (hs_r) r_hs++;
      if (p_aw && (!axi_awvalid_o || axi_awaddr_o != p_awaddr)) stab_err++;
      if (p_w && (!axi_wvalid_o || axi_wdata_o != p_wdata || axi_wstrb_o != p_wstrb)) stab_err++;
      if (p_ar && (!axi_arvalid_o || axi_araddr_o != p_araddr)) stab_err++;
      if (p_wr && (!noc_wr_o || noc_din_o != p_din)) stab_err++;
      if (noc_wr_o) wr_cycles++;
      if (noc_wr_o && !noc_wait_i) begin flit_cnt++; cap_flit = noc_din_o; end
      p_aw = axi_awvalid_o && !hs_aw; p_awaddr = axi_awaddr_o;
      p_w  = axi_wvalid_o && !hs_w;   p_wdata = axi_wdata_o; p_wstrb = axi_wstrb_o;
      p_ar = axi_arvalid_o && !hs_ar; p_araddr = axi_araddr_o;
      p_wr = noc_wr_o && noc_wait_i;  p_din = noc_din_o;

      @(posedge clk); #1;
      if (hs_aw) aw_flag = 1;
      if (hs_w)  w_flag = 1;
      if (hs_b)  axi_bvalid_i = 0;
      if (aw_flag && w_flag) begin
        if (!b_hold) begin axi_bvalid_i = 1; axi_bresp_i = slv_resp; end
        aw_flag = 0; w_flag = 0;
      end
      if (hs_r) axi_rvalid_i = 0;
      if (hs_ar) begin axi_rvalid_i = 1; axi_rdata_i = slv_rdata; axi_rresp_i = slv_resp; end
      axi_awready_i = axi_awvalid_o && (aw_cnt >= aw_dly);
      axi_wready_i  = axi_wvalid_o  && (w_cnt  >= w_dly);
      axi_arready_i = axi_arvalid_o && (ar_cnt >= ar_dly);
      aw_cnt = axi_awvalid_o ? aw_cnt + 1 : 0;
      w_cnt  = axi_wvalid_o  ? w_cnt + 1  : 0;
      ar_cnt = axi_arvalid_o ? ar_cnt + 1 : 0;
    end
  end

  typedef struct {
    string            name;
    logic [4:0]       src;
    logic [4:0]       dst;
    logic             wr;
    logic [3:0]       strb;
    logic [18:0]      wa;
    logic [31:0]      wdata;
    int               aw_dly;
    int               w_dly;
    int               ar_dly;
    logic [1:0]       slv_resp;
    logic [31:0]      slv_rdata;
    int               noc_wait;
    bit               exp_resp;
    logic [31:0]      exp_addr;
    logic [BUS_W-1:0] exp_flit;
    int               exp_lat;
    int               exp_a_cyc;
    int               exp_w_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int cyc;
    bit seen;
    aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly;
    slv_resp = v.slv_resp; slv_rdata = v.slv_rdata;
    clear_mon();
    noc_wait_i = (v.noc_wait > 0);
    noc_dout_i = {v.src, v.dst, v.wr, v.strb, v.wa, v.wdata};
    noc_nd_i = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin @(posedge clk); #1; cyc++; seen = noc_rd_o; end
    check({v.name, "_fetch"}, seen, 1'b1);
    @(posedge clk); #1; cyc++;
    noc_nd_i = 1'b0;
    noc_dout_i = '0;
    if (v.exp_resp) begin
      seen = noc_wr_o;
      while (!seen && cyc < 100) begin @(posedge clk); #1; cyc++; seen = noc_wr_o; end
      check({v.name, "_latency"}, cyc, v.exp_lat);
      repeat (v.noc_wait) begin @(posedge clk); #1; end
      noc_wait_i = 1'b0;
      cyc = 0;
      while (noc_wr_o && cyc < 20) begin @(posedge clk); #1; cyc++; end
    end else begin
      repeat (10) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    check({v.name, "_rd_pulses"}, rd_pulses, 1);
    if (v.exp_resp) begin
      check({v.name, "_flit_cnt"}, flit_cnt, 1);
      check({v.name, "_flit"}, cap_flit, v.exp_flit);
      check({v.name, "_axi_addr"}, cap_addr, v.exp_addr);
      check({v.name, "_wr_cycles"}, wr_cycles, v.noc_wait + 1);
      check({v.name, "_stability"}, stab_err, 0);
      if (v.wr) begin
        check({v.name, "_wdata"}, cap_wdata, v.wdata);
        check({v.name, "_wstrb"}, cap_wstrb, v.strb);
        check({v.name, "_aw_cycles"}, aw_cycles, v.exp_a_cyc);
        check({v.name, "_w_cycles"}, w_cycles, v.exp_w_cyc);
        check({v.name, "_b_hs"}, b_hs, 1);
      end else begin
        check({v.name, "_ar_cycles"}, ar_cycles, v.exp_a_cyc);
        check({v.name, "_r_hs"}, r_hs, 1);
      end
    end else begin
      check({v.name, "_flit_cnt"}, flit_cnt, 0);
      check({v.name, "_axi_valid"}, aw_cycles + w_cycles + ar_cycles, 0);
    end
    $display("txn %s: rd=%0d flits=%0d addr=%h flit=%h", v.name, rd_pulses, flit_cnt, cap_addr, cap_flit);
  endtask

  initial begin
    int cyc;
    bit seen;
    vecs[0] = '{name:"wr_basic", src:5'b01101, dst:5'b10010, wr:1'b1, strb:4'hF, wa:19'h00010,
                wdata:32'hDEADBEEF, aw_dly:0, w_dly:0, ar_dly:0, slv_resp:2'b00, slv_rdata:32'h0,
                noc_wait:0, exp_resp:1, exp_addr:32'h4000_0040,
                exp_flit:{5'b10010, 5'b01101, 56'h80_0010_0000_0000}, exp_lat:4, exp_a_cyc:1, exp_w_cyc:1};
    vecs[1] = '{name:"rd_arwait", src:5'b00001, dst:5'b10010, wr:1'b0, strb:4'h0, wa:19'h00003,
                wdata:32'h0, aw_dly:0, w_dly:0, ar_dly:3, slv_resp:2'b00, slv_rdata:32'h12345678,
                noc_wait:0, exp_resp:1, exp_addr:32'h4000_000C,
                exp_flit:{5'b10010, 5'b00001, 56'h00_0003_1234_5678}, exp_lat:7, exp_a_cyc:4, exp_w_cyc:0};
    vecs[2] = '{name:"wr_wlag", src:5'b11111, dst:5'b10010, wr:1'b1, strb:4'h3, wa:19'h7FFFF,
                wdata:32'h0000A5A5, aw_dly:0, w_dly:2, ar_dly:0, slv_resp:2'b00, slv_rdata:32'h0,
                noc_wait:0, exp_resp:1, exp_addr:32'h401F_FFFC,
                exp_flit:{5'b10010, 5'b11111, 56'h87_FFFF_0000_0000}, exp_lat:6, exp_a_cyc:1, exp_w_cyc:3};
    vecs[3] = '{name:"rd_slverr", src:5'b01010, dst:5'b10010, wr:1'b0, strb:4'h0, wa:19'h00100,
                wdata:32'h0, aw_dly:0, w_dly:0, ar_dly:0, slv_resp:2'b10, slv_rdata:32'hCAFEF00D,
                noc_wait:0, exp_resp:1, exp_addr:32'h4000_0400,
                exp_flit:{5'b10010, 5'b01010, 56'h40_0100_CAFE_F00D}, exp_lat:4, exp_a_cyc:1, exp_w_cyc:0};
    vecs[4] = '{name:"wr_decerr", src:5'b00110, dst:5'b10010, wr:1'b1, strb:4'h1, wa:19'h00000,
                wdata:32'h00000011, aw_dly:0, w_dly:0, ar_dly:0, slv_resp:2'b11, slv_rdata:32'h0,
                noc_wait:0, exp_resp:1, exp_addr:32'h4000_0000,
                exp_flit:{5'b10010, 5'b00110, 56'hE0_0000_0000_0000}, exp_lat:4, exp_a_cyc:1, exp_w_cyc:1};
    vecs[5] = '{name:"rd_nocwait", src:5'b00011, dst:5'b10010, wr:1'b0, strb:4'h0, wa:19'h00004,
                wdata:32'h0, aw_dly:0, w_dly:0, ar_dly:0, slv_resp:2'b00, slv_rdata:32'h89ABCDEF,
                noc_wait:5, exp_resp:1, exp_addr:32'h4000_0010,
                exp_flit:{5'b10010, 5'b00011, 56'h00_0004_89AB_CDEF}, exp_lat:4, exp_a_cyc:1, exp_w_cyc:0};
    vecs[6] = '{name:"drop_local", src:5'b01101, dst:5'b10011, wr:1'b1, strb:4'hF, wa:19'h00005,
                wdata:32'h00000001, aw_dly:0, w_dly:0, ar_dly:0, slv_resp:2'b00, slv_rdata:32'h0,
                noc_wait:0, exp_resp:0, exp_addr:32'h0, exp_flit:'0, exp_lat:0, exp_a_cyc:0, exp_w_cyc:0};
    vecs[7] = '{name:"drop_x", src:5'b00001, dst:5'b00010, wr:1'b0, strb:4'h0, wa:19'h00001,
                wdata:32'h0, aw_dly:0, w_dly:0, ar_dly:0, slv_resp:2'b00, slv_rdata:32'h0,
                noc_wait:0, exp_resp:0, exp_addr:32'h0, exp_flit:'0, exp_lat:0, exp_a_cyc:0, exp_w_cyc:0};

    aw_dly = 0; w_dly = 0; ar_dly = 0; slv_resp = 0; slv_rdata = 0; b_hold = 0;
    clear_mon();
    noc_dout_i = '0; noc_nd_i = 0; noc_wait_i = 0;
    rst_n_i = 1'b0;
    #2;
    check("reset_outputs", any_out, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n_i = 1'b1;
    @(posedge clk); #1;
    check("idle_outputs", any_out, 1'b0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while waiting for the write response abandons the transaction
    clear_mon();
    b_hold = 1; aw_dly = 0; w_dly = 0; slv_resp = 2'b00;
    noc_dout_i = {5'b01101, 5'b10010, 1'b1, 4'hF, 19'h00020, 32'h55AA55AA};
    noc_nd_i = 1'b1;
    cyc = 0; seen = 0;
    while (!seen && cyc < 20) begin @(posedge clk); #1; cyc++; seen = noc_rd_o; end
    @(posedge clk); #1;
    noc_nd_i = 1'b0; noc_dout_i = '0;
    cyc = 0; seen = axi_bready_o;
    while (!seen && cyc < 20) begin @(posedge clk); #1; cyc++; seen = axi_bready_o; end
    check("rst_mid_bready", seen, 1'b1);
    #2 rst_n_i = 1'b0;
    #1 check("rst_mid_async_outputs", any_out, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("rst_mid_held_outputs", any_out, 1'b0);
    rst_n_i = 1'b1;
    b_hold = 0;
    clear_mon();
    repeat (10) begin @(posedge clk); #1; end
    check("rst_mid_no_flit", flit_cnt, 0);
    check("rst_mid_no_wr", wr_cycles, 0);
    $display("txn rst_mid_wr_resp: flits=%0d wr_cycles=%0d", flit_cnt, wr_cycles);
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
